// File: rtl/uart_baud_pkg.sv
// Shared types and helpers for the fractional UART baud generator.
package uart_baud_pkg;

    typedef enum logic [1:0] {
        OSR8    = 2'b00,
        OSR16   = 2'b01,
        OSR32   = 2'b10,
        OSR_RSV = 2'b11
    } osr_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bg_state_e;

    localparam int DIV_MIN = 2;
    localparam int IDX_W   = 5;

    // Oversample ticks per bit; the reserved code behaves as 16x.
    function automatic logic [5:0] osr_count(input osr_e osr);
        case (osr)
            OSR8:    osr_count = 6'd8;
            OSR32:   osr_count = 6'd32;
            default: osr_count = 6'd16;
        endcase
    endfunction

    // Last oversample index before the bit wraps.
    function automatic logic [IDX_W-1:0] osr_last(input osr_e osr);
        return IDX_W'(osr_count(osr) - 6'd1);
    endfunction

endpackage

// File: rtl/baud_frac_divider.sv
// Down-counter plus fractional accumulator producing the oversample strobe.
// A period is div_int cycles, stretched by one whenever the accumulator
// carries, so the long-run average is div_int + div_frac/2^FRAC_W.
module baud_frac_divider
    import uart_baud_pkg::*;
#(
    parameter int INT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              run,
    input  logic              clear,
    input  logic              reload,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              period_end,
    output logic              os_tick
);

    logic [INT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum    = {1'b0, acc} + {1'b0, div_frac};
    assign period_end = run && !clear && !reload && (cnt == '0);

    // Counter/accumulator update; clear and reload both suppress the strobe.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt     <= '0;
            acc     <= '0;
            os_tick <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            acc     <= '0;
            os_tick <= 1'b0;
        end else if (reload) begin
            cnt     <= div_int - INT_W'(1);
            acc     <= '0;
            os_tick <= 1'b0;
        end else if (period_end) begin
            cnt     <= div_int - INT_W'(1) + INT_W'(acc_sum[FRAC_W]);
            acc     <= acc_sum[FRAC_W-1:0];
            os_tick <= 1'b1;
        end else if (run) begin
            cnt     <= cnt - INT_W'(1);
            os_tick <= 1'b0;
        end else begin
            os_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_baudgen_frac.sv
// Fractional UART baud generator: oversample and bit strobes with a
// programmable divisor, shadowed config swapped on bit boundaries, and a
// resync input for Rx start-bit alignment.
module uart_baudgen_frac
    import uart_baud_pkg::*;
#(
    parameter int         INT_W       = 16,
    parameter int         FRAC_W      = 4,
    parameter int         DEF_DIV_INT = 54,
    parameter logic [1:0] DEF_OSR     = 2'b00
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_en,
    input  logic [INT_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic [1:0]        i_osr,
    input  logic              i_cfg_load,
    input  logic              i_resync,
    output logic              o_os_tick,
    output logic              o_bit_tick,
    output logic [4:0]        o_os_idx,
    output logic              o_cfg_pend,
    output logic              o_cfg_err
);

    bg_state_e         state;

    logic [INT_W-1:0]  act_int;
    logic [FRAC_W-1:0] act_frac;
    osr_e              act_osr;
    logic [INT_W-1:0]  shd_int;
    logic [FRAC_W-1:0] shd_frac;
    osr_e              shd_osr;

    logic              load_ok;
    logic              load_bad;
    logic              go_run;
    logic              in_run;
    logic              leaving;
    logic              resync;
    logic              apply;
    logic              div_reload;
    logic [INT_W-1:0]  cand_int;
    logic [FRAC_W-1:0] cand_frac;
    osr_e              cand_osr;
    logic [INT_W-1:0]  sel_int;
    logic [4:0]        idx_last;
    logic              period_end;

    // Control decode: a fresh legal load overrides the shadow, and a new
    // config takes effect one cycle after a bit strobe or at a resync.
    always_comb begin
        load_ok    = i_cfg_load && (i_div_int >= INT_W'(DIV_MIN));
        load_bad   = i_cfg_load && !load_ok;
        cand_int   = load_ok ? i_div_int  : shd_int;
        cand_frac  = load_ok ? i_div_frac : shd_frac;
        cand_osr   = load_ok ? osr_e'(i_osr) : shd_osr;
        go_run     = (state == IDLE) && i_en;
        in_run     = (state == RUN) && i_en;
        leaving    = (state == RUN) && !i_en;
        resync     = in_run && i_resync;
        apply      = in_run && (o_cfg_pend || load_ok) && (o_bit_tick || i_resync);
        div_reload = go_run || resync || apply;
        idx_last   = osr_last(act_osr);
        if (go_run) begin
            sel_int = load_ok ? i_div_int : act_int;
        end else if (apply) begin
            sel_int = cand_int;
        end else begin
            sel_int = act_int;
        end
    end

    baud_frac_divider #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .i_clk      (i_clk),
        .i_arst_n   (i_arst_n),
        .run        (state == RUN),
        .clear      (leaving),
        .reload     (div_reload),
        .div_int    (sel_int),
        .div_frac   (act_frac),
        .period_end (period_end),
        .os_tick    (o_os_tick)
    );

    // FSM with config registers, oversample index and bit strobe.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state      <= IDLE;
            act_int    <= INT_W'(DEF_DIV_INT);
            act_frac   <= '0;
            act_osr    <= osr_e'(DEF_OSR);
            shd_int    <= INT_W'(DEF_DIV_INT);
            shd_frac   <= '0;
            shd_osr    <= osr_e'(DEF_OSR);
            o_cfg_pend <= 1'b0;
            o_cfg_err  <= 1'b0;
            o_os_idx   <= '0;
            o_bit_tick <= 1'b0;
        end else begin
            if (load_bad) begin
                o_cfg_err <= 1'b1;
            end else if (load_ok) begin
                o_cfg_err <= 1'b0;
            end
            if (load_ok) begin
                shd_int  <= i_div_int;
                shd_frac <= i_div_frac;
                shd_osr  <= osr_e'(i_osr);
            end
            case (state)
                IDLE: begin
                    o_os_idx   <= '0;
                    o_bit_tick <= 1'b0;
                    if (load_ok) begin
                        act_int  <= i_div_int;
                        act_frac <= i_div_frac;
                        act_osr  <= osr_e'(i_osr);
                    end
                    if (i_en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!i_en) begin
                        state      <= IDLE;
                        o_os_idx   <= '0;
                        o_bit_tick <= 1'b0;
                        o_cfg_pend <= 1'b0;
                        if (o_cfg_pend || load_ok) begin
                            act_int  <= cand_int;
                            act_frac <= cand_frac;
                            act_osr  <= cand_osr;
                        end
                    end else begin
                        if (apply) begin
                            act_int    <= cand_int;
                            act_frac   <= cand_frac;
                            act_osr    <= cand_osr;
                            o_cfg_pend <= 1'b0;
                        end else if (load_ok) begin
                            o_cfg_pend <= 1'b1;
                        end
                        if (resync) begin
                            o_os_idx   <= '0;
                            o_bit_tick <= 1'b0;
                        end else if (period_end) begin
                            o_os_idx   <= (o_os_idx >= idx_last) ? 5'd0 : o_os_idx + 5'd1;
                            o_bit_tick <= (o_os_idx >= idx_last);
                        end else begin
                            o_bit_tick <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_baudgen_frac.sv
// Directed self-checking bench for uart_baudgen_frac. Inputs change on the
// falling edge and outputs are sampled on the falling edge. Tick latencies
// are counted in rising edges from the edge that samples the stimulus.
module tb_uart_baudgen_frac;

    logic        clk;
    logic        arst_n;
    logic        en;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic [1:0]  osr;
    logic        cfg_load;
    logic        resync;
    logic        os_tick;
    logic        bit_tick;
    logic [4:0]  os_idx;
    logic        cfg_pend;
    logic        cfg_err;

    int total = 0;
    int bad   = 0;
    int n;
    int c27;
    int c28;
    int cother;

    uart_baudgen_frac dut (
        .i_clk      (clk),
        .i_arst_n   (arst_n),
        .i_en       (en),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .i_osr      (osr),
        .i_cfg_load (cfg_load),
        .i_resync   (resync),
        .o_os_tick  (os_tick),
        .o_bit_tick (bit_tick),
        .o_os_idx   (os_idx),
        .o_cfg_pend (cfg_pend),
        .o_cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle config load pulse; returns on the falling edge after capture.
    task automatic applyStimulus(input int di, input int df, input int os);
        div_int  = 16'(di);
        div_frac = 4'(df);
        osr      = 2'(os);
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    // Falling edges until the next oversample strobe (bounded).
    task automatic waitTick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!os_tick && cycles < 5000);
    endtask

    // Falling edges until the next bit strobe (bounded).
    task automatic waitBit(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bit_tick && cycles < 5000);
    endtask

    initial begin
        arst_n   = 1'b0;
        en       = 1'b0;
        div_int  = 16'd0;
        div_frac = 4'd0;
        osr      = 2'd0;
        cfg_load = 1'b0;
        resync   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_os_tick", os_tick, 0);
        checkOutput("rst_bit_tick", bit_tick, 0);
        checkOutput("rst_os_idx", os_idx, 0);
        checkOutput("rst_cfg_pend", cfg_pend, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default config: 54-cycle ticks, 8 per bit
        $display("[TB] default divisor");
        en = 1'b1;
        @(negedge clk);
        waitTick(n);
        checkOutput("first_tick", n, 54);
        checkOutput("idx_after_first", os_idx, 1);
        for (int k = 2; k <= 8; k++) begin
            waitTick(n);
            checkOutput($sformatf("def_period_%0d", k), n, 54);
            checkOutput($sformatf("def_idx_%0d", k), os_idx, k % 8);
        end
        checkOutput("def_bit_tick", bit_tick, 1);
        waitBit(n);
        checkOutput("def_bit_period", n, 432);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_idx", os_idx, 0);
        checkOutput("idle_tick", os_tick, 0);

        // Fractional divisor 27 + 2/16, 16x oversampling
        $display("[TB] fractional divisor");
        applyStimulus(27, 2, 1);
        checkOutput("frac_pend_idle", cfg_pend, 0);
        en = 1'b1;
        @(negedge clk);
        waitTick(n);
        checkOutput("frac_first", n, 27);
        c27 = 0;
        c28 = 0;
        cother = 0;
        for (int k = 0; k < 16; k++) begin
            waitTick(n);
            if (n == 27) c27++;
            else if (n == 28) c28++;
            else cother++;
        end
        checkOutput("frac_cnt27", c27, 14);
        checkOutput("frac_cnt28", c28, 2);
        checkOutput("frac_other", cother, 0);
        waitBit(n);
        waitBit(n);
        checkOutput("frac_bit_period", n, 434);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Mid-bit load of 13 / 32x waits for the bit boundary
        $display("[TB] pending config");
        applyStimulus(54, 0, 0);
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) waitTick(n);
        checkOutput("pend_idx3", os_idx, 3);
        repeat (5) @(negedge clk);
        applyStimulus(13, 0, 2);
        checkOutput("pend_set", cfg_pend, 1);
        waitTick(n);
        checkOutput("pend_idx4", os_idx, 4);
        for (int k = 5; k <= 8; k++) begin
            waitTick(n);
            checkOutput($sformatf("pend_old_period_%0d", k), n, 54);
        end
        checkOutput("pend_boundary_bit", bit_tick, 1);
        waitTick(n);
        checkOutput("pend_cleared", cfg_pend, 0);
        waitTick(n);
        checkOutput("pend_new_period", n, 13);
        waitBit(n);
        waitBit(n);
        checkOutput("pend_new_bit_period", n, 416);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Illegal load is rejected and flagged
        $display("[TB] illegal load");
        applyStimulus(54, 0, 0);
        en = 1'b1;
        @(negedge clk);
        waitTick(n);
        checkOutput("ill_first", n, 54);
        applyStimulus(1, 0, 0);
        checkOutput("ill_err_set", cfg_err, 1);
        checkOutput("ill_no_pend", cfg_pend, 0);
        waitTick(n);
        waitTick(n);
        checkOutput("ill_period_kept", n, 54);
        applyStimulus(27, 0, 0);
        checkOutput("ill_err_clear", cfg_err, 0);
        checkOutput("ill_legal_pend", cfg_pend, 1);
        en = 1'b0;
        repeat (2) @(negedge clk);

        // Resync mid-period and on a tick cycle
        $display("[TB] resync");
        applyStimulus(54, 0, 0);
        en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) waitTick(n);
        checkOutput("rs_idx5", os_idx, 5);
        repeat (20) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        checkOutput("rs_no_tick", os_tick, 0);
        checkOutput("rs_idx0", os_idx, 0);
        waitTick(n);
        checkOutput("rs_next_tick", n, 54);
        checkOutput("rs_idx1", os_idx, 1);
        repeat (53) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        checkOutput("rs_tick_suppressed", os_tick, 0);
        checkOutput("rs_tick_idx0", os_idx, 0);
        waitTick(n);
        checkOutput("rs_after_suppress", n, 54);

        // Reset mid-bit discards a pending config
        $display("[TB] reset with pending config");
        for (int k = 0; k < 3; k++) waitTick(n);
        repeat (10) @(negedge clk);
        applyStimulus(13, 0, 2);
        checkOutput("ar_pend_set", cfg_pend, 1);
        repeat (5) @(negedge clk);
        arst_n = 1'b0;
        #1;
        checkOutput("ar_os_tick", os_tick, 0);
        checkOutput("ar_bit_tick", bit_tick, 0);
        checkOutput("ar_os_idx", os_idx, 0);
        checkOutput("ar_cfg_pend", cfg_pend, 0);
        checkOutput("ar_cfg_err", cfg_err, 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        waitTick(n);
        checkOutput("ar_first_tick", n, 54);
        waitTick(n);
        checkOutput("ar_period", n, 54);
        checkOutput("ar_no_pend", cfg_pend, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_baudgen_frac.md
Name: uart_baudgen_frac

Overview:
Parametrised successor to the UART baud tick generator. Produces oversample and bit-rate strobes from i_clk using a runtime-programmable integer+fractional divisor and a selectable oversampling ratio (8/16/32). Shared by the UART Tx and Rx datapaths. Supports glitch-free config updates on bit boundaries and a resync input for Rx start-bit alignment.

Parameters:
INT_W, 16, width of integer divisor (i_clk cycles per oversample tick).
FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W cycle).
DEF_DIV_INT, 54, integer divisor loaded at reset.
DEF_OSR, 2'b00, oversampling select loaded at reset (8x).

Ports:
i_clk  in  1  system clock
i_arst_n  in  1  async reset, active low
i_en  in  1  run enable; low holds the generator idle
i_div_int  in  INT_W  integer divisor, legal range 2..2^INT_W-1
i_div_frac  in  FRAC_W  fractional divisor
i_osr  in  2  00=8x, 01=16x, 10=32x, 11=reserved
i_cfg_load  in  1  one-cycle pulse; capture i_div_int/i_div_frac/i_osr
i_resync  in  1  one-cycle pulse; restart phase at zero
o_os_tick  out  1  one-cycle oversample strobe
o_bit_tick  out  1  one-cycle bit strobe, coincident with the os tick closing a bit
o_os_idx  out  5  oversample index within the current bit, 0..OSR-1
o_cfg_pend  out  1  a loaded config is waiting for a bit boundary
o_cfg_err  out  1  sticky; last load was illegal

Behaviour:
- Reset is i_arst_n, asynchronous, active-low; clock is i_clk. All state is updated on the posedge of i_clk.
- Reset values: all outputs 0. Active config = DEF_DIV_INT, frac 0, DEF_OSR. Down-counter, accumulator and o_os_idx = 0.
- States: IDLE, RUN.
  - IDLE -> RUN when i_en=1. The counter loads div_int-1, so the first o_os_tick arrives div_int cycles after i_en rises.
  - RUN -> IDLE when i_en=0, on the next cycle. The counter, accumulator and o_os_idx clear, and no ticks are emitted.
- Period generation:
  - The counter decrements each cycle. At 0, assert o_os_tick for one cycle.
  - On each os tick: acc_next = acc + div_frac (FRAC_W+1 bits). The carry-out makes the next period div_int+1 cycles, otherwise div_int; acc keeps the low FRAC_W bits.
  - Over 2^FRAC_W ticks the total is exactly div_int*2^FRAC_W + div_frac cycles. With frac=0 every period is exactly div_int.
- Bit framing:
  - o_os_idx increments on each os tick and wraps OSR-1 -> 0.
  - o_bit_tick=1 in the same cycle as the os tick where o_os_idx wraps.
  - i_osr=11 is treated as 16x.
- Config load:
  - i_cfg_load with i_div_int<2: rejected, o_cfg_err=1. The active and pending config are unchanged.
  - Legal load with i_cfg_load=1: o_cfg_err clears and the values go to shadow regs.
    - In IDLE: applied immediately.
    - In RUN: o_cfg_pend=1 and the shadow is applied in the cycle after the next o_bit_tick. At that point the counter reloads with the new div_int-1, acc=0, and o_cfg_pend clears.
  - A second load while pending overwrites the shadow.
- Resync (RUN only; ignored in IDLE):
  - The counter reloads div_int-1, acc=0, o_os_idx=0, and no tick is emitted that cycle.
  - If i_resync coincides with a tick, the resync wins and the tick is suppressed.
  - A pending config is applied at the resync instead of waiting for a bit boundary.
  - i_resync and i_cfg_load in the same cycle: the new legal config is applied, then the phase restarts.
- Reset asserted mid-operation: everything returns to reset values immediately; a pending config is discarded.

Decomposition:
- Package uart_baud_pkg:
  - osr_e enum (OSR8, OSR16, OSR32, OSR_RSV).
  - Function osr_count(osr_e) returning 8/16/32, with 16 for OSR_RSV.
  - Constant DIV_MIN=2.
  - State enum bg_state_e {IDLE, RUN}.
- Sub-module baud_frac_divider: holds the down-counter and fractional accumulator, and emits the os tick. The top level owns the FSM, OSR index, shadow config and error logic.

Test Plan:
- Default config after reset, i_en=1: o_os_tick every 54 cycles, o_bit_tick every 432 cycles, first os tick at cycle 54 after i_en rises; o_os_idx counts 0..7.
- Fractional divisor: load div_int=27, frac=2, osr=16x (FRAC_W=4): exactly 2 periods of 28 and 14 of 27 per 16 ticks, 434 cycles per bit; no period other than 27/28.
- Load div_int=13, osr=32x mid-bit at o_os_idx=3: o_cfg_pend=1, old 54-cycle period holds until o_bit_tick; new periods are 13 cycles and 32 ticks per bit; o_cfg_pend then clears.
- Illegal load div_int=1: o_cfg_err=1 and the period stays 54; a following legal load of 27 clears o_cfg_err.
- i_resync at o_os_idx=5, 20 cycles into a period: no tick that cycle, o_os_idx=0, next os tick exactly 54 cycles later; resync on a tick cycle suppresses that tick.
- i_arst_n low mid-bit with a pending config: all outputs 0; after release the generator runs the DEF_DIV_INT period and the pending config is discarded.
